// File: rtl/hv_hamming_classifier_if.sv
// Bus between the query source (bundler + prototype ROM side) and the
// Hamming-distance classifier. Parameters must match the classifier's.
//
// Handshake: there is no ready. A chunk is accepted on a rising clk edge
// exactly when in_valid=1, the classifier is accumulating and start=0.
// in_valid in any other cycle is ignored. proto_bits must reflect the ROM
// contents at chunk_addr combinationally in that same cycle. done is a
// one-cycle pulse; class_out and dist_out are valid from done onwards and
// hold until the next start or rst.
interface hv_hamming_classifier_if #(
  parameter int DIM         = 10000,
  parameter int PAR_BITS    = 2,
  parameter int NUM_CLASSES = 2
);
  localparam int NUM_CHUNKS = DIM / PAR_BITS;
  localparam int DIST_W     = $clog2(DIM + 1);
  localparam int ADDR_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                                   start;
  logic                                   in_valid;
  logic [PAR_BITS-1:0]                    in_bits;
  logic [NUM_CLASSES-1:0][PAR_BITS-1:0]   proto_bits;
  logic [ADDR_W-1:0]                      chunk_addr;
  logic                                   busy;
  logic                                   done;
  logic [CLS_W-1:0]                       class_out;
  logic [NUM_CLASSES-1:0][DIST_W-1:0]     dist_out;
  logic [1:0]                             state_dbg;

  modport master (
    output start, in_valid, in_bits, proto_bits,
    input  chunk_addr, busy, done, class_out, dist_out, state_dbg
  );

  modport slave (
    input  start, in_valid, in_bits, proto_bits,
    output chunk_addr, busy, done, class_out, dist_out, state_dbg
  );
endinterface

// File: rtl/hv_hamming_classifier.sv
// Nearest-prototype classifier for bundled query hypervectors. Chunks of the
// query arrive PAR_BITS at a time; each class keeps a running Hamming
// distance against its prototype. After the last chunk the smallest distance
// wins (ties to the lowest class index) and all distances are reported.
module hv_hamming_classifier #(
  parameter int DIM         = 10000,
  parameter int PAR_BITS    = 2,
  parameter int NUM_CLASSES = 2
) (
  input logic                   clk,
  input logic                   rst,
  hv_hamming_classifier_if.slave bus
);
  localparam int NUM_CHUNKS = DIM / PAR_BITS;
  localparam int DIST_W     = $clog2(DIM + 1);
  localparam int ADDR_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                             state_q;
  logic [ADDR_W-1:0]                  addr_q;
  logic [NUM_CLASSES-1:0][DIST_W-1:0] acc_q;
  logic [NUM_CLASSES-1:0][DIST_W-1:0] acc_next;
  logic [NUM_CLASSES-1:0][DIST_W-1:0] dist_q;
  logic [CLS_W-1:0]                   class_q;
  logic [CLS_W-1:0]                   best_idx;
  logic [DIST_W-1:0]                  best_dist;
  logic                               busy_q;
  logic                               done_q;

  // Running distances including the chunk currently on the bus.
  always_comb begin
    acc_next = acc_q;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int b = 0; b < PAR_BITS; b++) begin
        acc_next[c] = acc_next[c] + DIST_W'(bus.in_bits[b] ^ bus.proto_bits[c][b]);
      end
    end
  end

  // Argmin over the finished distances; strict '<' keeps the lowest index on ties.
  always_comb begin
    best_idx  = '0;
    best_dist = acc_q[0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (acc_q[c] < best_dist) begin
        best_dist = acc_q[c];
        best_idx  = CLS_W'(c);
      end
    end
  end

  // Query sequencing: start restarts from anywhere, then chunks accumulate,
  // one cycle to latch the decision, one cycle of done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      dist_q  <= '0;
      class_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.start) begin
      state_q <= ACCUM;
      addr_q  <= '0;
      acc_q   <= '0;
      dist_q  <= '0;
      class_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc_q <= acc_next;
            if (addr_q == LAST_ADDR) begin
              addr_q  <= '0;
              state_q <= DECIDE;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        DECIDE: begin
          class_q <= best_idx;
          dist_q  <= acc_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.chunk_addr = addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.class_out  = class_q;
  assign bus.dist_out   = dist_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_hv_hamming_classifier.sv
// Bench for the Hamming classifier at DIM=8, PAR_BITS=2, NUM_CLASSES=2.
// A query-level model predicts every output each cycle; directed tests add
// hand-computed literal expectations for distances, class and latency.
module tb_hv_hamming_classifier;
  localparam int DIM = 8;
  localparam int PB  = 2;
  localparam int NC  = 2;
  localparam int NCH = DIM / PB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hv_hamming_classifier_if #(.DIM(DIM), .PAR_BITS(PB), .NUM_CLASSES(NC)) bus ();

  hv_hamming_classifier #(.DIM(DIM), .PAR_BITS(PB), .NUM_CLASSES(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- prototype ROM (async read) ----------------
  logic [1:0] rom [NC][NCH];

  always_comb begin
    for (int c = 0; c < NC; c++) bus.proto_bits[c] = rom[c][bus.chunk_addr];
  end

  // ---------------- bookkeeping ----------------
  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- query-level model ----------------
  // Expected outputs after each edge, in query terms: how many chunks have
  // been taken, the distance sums so far, and whether a result is due.
  int         m_cnt     = 0;
  int         m_d [NC];
  bit         m_active  = 1'b0;
  bit         m_pending = 1'b0;
  logic       e_busy    = 1'b0;
  logic       e_done    = 1'b0;
  logic       e_class   = 1'b0;
  logic [NC-1:0][3:0] e_dist = '0;

  initial begin
    for (int c = 0; c < NC; c++) m_d[c] = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0; m_active = 0; m_pending = 0;
        e_busy = 0; e_done = 0; e_class = 0; e_dist = '0;
        for (int c = 0; c < NC; c++) m_d[c] = 0;
      end else begin
        e_done = 0;
        if (bus.start) begin
          m_cnt = 0; m_active = 1; m_pending = 0;
          e_busy = 1; e_class = 0; e_dist = '0;
          for (int c = 0; c < NC; c++) m_d[c] = 0;
        end else if (m_pending) begin
          m_pending = 0;
          e_busy    = 0;
          e_done    = 1;
          e_class   = 0;
          for (int c = 0; c < NC; c++) begin
            e_dist[c] = 4'(m_d[c]);
            if (m_d[c] < m_d[e_class]) e_class = 1'(c);
          end
          exp_q.push_back({e_class, e_dist});
        end else if (m_active && bus.in_valid) begin
          for (int c = 0; c < NC; c++) m_d[c] += $countones(bus.in_bits ^ rom[c][m_cnt]);
          m_cnt++;
          if (m_cnt == NCH) begin
            m_cnt = 0; m_active = 0; m_pending = 1;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [8:0] r;
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        check("chunk_addr", bus.chunk_addr, m_cnt);
        check("busy", bus.busy, e_busy);
        check("done", bus.done, e_done);
        check("class_out", bus.class_out, e_class);
        check("dist0", bus.dist_out[0], e_dist[0]);
        check("dist1", bus.dist_out[1], e_dist[1]);
        if (bus.done === 1'b1) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_done: got done=1 expected no result pending at %0t", $time);
          end else begin
            r = exp_q.pop_front();
            check("sb_result", {bus.class_out, bus.dist_out}, r);
          end
        end
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic set_rom(input logic [7:0] p0, input logic [7:0] p1);
    for (int k = 0; k < NCH; k++) begin
      rom[0][k] = p0[2*k +: 2];
      rom[1][k] = p1[2*k +: 2];
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_chunk(input logic [1:0] b, input int gap);
    bus.in_valid = 1'b1;
    bus.in_bits  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_bits  = '0;
    repeat (gap) @(negedge clk);
  endtask

  // Last chunk always goes without a trailing gap so latency can be pinned.
  task automatic send_query(input logic [7:0] q, input int gap);
    for (int k = 0; k < NCH; k++) send_chunk(q[2*k +: 2], (k == NCH - 1) ? 0 : gap);
  endtask

  // Called right after send_query: one decision cycle, then the done pulse.
  task automatic expect_result(input string tag, input int cls, input int d0, input int d1);
    check({tag, "_no_early_done"}, bus.done, 0);
    @(negedge clk);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_class"}, bus.class_out, cls);
    check({tag, "_dist0"}, bus.dist_out[0], d0);
    check({tag, "_dist1"}, bus.dist_out[1], d1);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_class_hold"}, bus.class_out, cls);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int saved;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bits  = '0;
    set_rom(8'h00, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 1. reset values, then in_valid with no start is ignored
    check("rst_chunk_addr", bus.chunk_addr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_class", bus.class_out, 0);
    check("rst_dist", bus.dist_out, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    set_rom(8'b11_10_01_00, 8'b00_01_10_11);
    send_chunk(2'b01, 1);
    send_chunk(2'b10, 1);
    send_chunk(2'b11, 2);
    check("idle_chunk_addr", bus.chunk_addr, 0);
    check("idle_no_done", done_cnt, 0);

    // 2. exact match
    do_start();
    check("t2_busy", bus.busy, 1);
    send_query(8'b11_10_01_00, 0);
    expect_result("t2", 0, 0, 8);
    repeat (2) @(negedge clk);

    // 3. tie goes to class 0
    set_rom(8'hFF, 8'hFF);
    do_start();
    send_query(8'h00, 0);
    expect_result("t3", 0, 8, 8);
    @(negedge clk);

    // 4. bubbles: in_valid every 10 cycles
    set_rom(8'b11_10_01_00, 8'b00_01_10_11);
    do_start();
    send_chunk(2'b00, 5);
    check("t4_addr_hold", bus.chunk_addr, 1);
    repeat (4) @(negedge clk);
    send_chunk(2'b01, 9);
    send_chunk(2'b10, 9);
    send_chunk(2'b11, 0);
    expect_result("t4", 0, 0, 8);
    @(negedge clk);

    // 5. restart after chunk 2; fresh query matches proto1
    saved = done_cnt;
    do_start();
    send_chunk(2'b00, 0);
    send_chunk(2'b01, 0);
    send_chunk(2'b10, 0);
    do_start();
    check("t5_addr_cleared", bus.chunk_addr, 0);
    send_query(8'b00_01_10_11, 0);
    expect_result("t5", 1, 8, 0);
    repeat (3) @(negedge clk);
    check("t5_one_done", done_cnt, saved + 1);

    // 6. reset mid-query: outputs clear before the next edge, no done
    saved = done_cnt;
    do_start();
    send_chunk(2'b00, 0);
    send_chunk(2'b01, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_addr", bus.chunk_addr, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_done", bus.done, 0);
    check("t6_rst_class", bus.class_out, 0);
    check("t6_rst_dist", bus.dist_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_no_done", done_cnt, saved);
    do_start();
    send_query(8'b11_10_01_00, 0);
    expect_result("t6", 0, 0, 8);
    @(negedge clk);

    // 7. mixed pattern: query 11,00,11,00 vs proto0 all 10 and proto1 01,00,11,01
    set_rom(8'b10_10_10_10, 8'b01_11_00_01);
    do_start();
    send_query(8'b00_11_00_11, 2);
    expect_result("t7", 1, 4, 2);
    repeat (3) @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
